// File: rtl/dbg_run_ctrl.sv
// rtl/dbg_run_ctrl.sv - debug run-control unit between core commit stage and debugger
//
// Purpose:
//   Watches the retire stream, stalls the core when halted or draining, and
//   executes host run/halt/step/breakpoint commands. Reports halt state, cause
//   and the PC/encoding of the last retired instruction, and counts retirements.
//
// Ports:
//   clk, reset          single clock; asynchronous active-low reset
//   commit_valid        one instruction retires this cycle
//   commit_pc/inst      PC and encoding of the retiring instruction
//   commit_brk/ivd      retiring instruction is ebreak / illegal
//   core_idle           nothing in flight in the core
//   cmd_valid/ready     host command handshake
//   cmd_op/idx/addr     command opcode, breakpoint slot, breakpoint PC
//   cmd_err             one-cycle pulse for an illegal or ignored command
//   core_stall          core must not issue
//   halted, halt_cause  halt status and reason
//   halt_pc/inst        last retired instruction at halt time
//   instret             retired-instruction counter (wraps)

module dbg_run_ctrl #(
  parameter int NUM_BP       = 4,
  parameter int CNT_W        = 32,
  parameter bit START_HALTED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_inst,
  input  logic             commit_brk,
  input  logic             commit_ivd,
  input  logic             core_idle,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_idx,
  input  logic [31:0]      cmd_addr,
  output logic             cmd_err,
  output logic             core_stall,
  output logic             halted,
  output logic [2:0]       halt_cause,
  output logic [31:0]      halt_pc,
  output logic [31:0]      halt_inst,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] ST_RUNNING  = 2'd0;
  localparam logic [1:0] ST_HALTED   = 2'd1;
  localparam logic [1:0] ST_DRAINING = 2'd2;
  localparam logic [1:0] ST_STEPPING = 2'd3;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_RESET   = 3'd1;
  localparam logic [2:0] CAUSE_HOST    = 3'd2;
  localparam logic [2:0] CAUSE_STEP    = 3'd3;
  localparam logic [2:0] CAUSE_BP      = 3'd4;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd5;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd6;

  localparam logic [2:0] OP_RUN    = 3'd0;
  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_SET_BP = 3'd3;
  localparam logic [2:0] OP_CLR_BP = 3'd4;

  localparam logic [3:0] NUM_BP_L = 4'(NUM_BP);

  localparam logic [1:0] ST_RESET    = START_HALTED ? ST_HALTED : ST_RUNNING;
  localparam logic [2:0] CAUSE_RST_V = START_HALTED ? CAUSE_RESET : CAUSE_NONE;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [2:0]        cause_nxt;
  logic [31:0]       pc_nxt;
  logic [31:0]       inst_nxt;
  logic [NUM_BP-1:0] bp_en;
  logic [31:0]       bp_addr [NUM_BP];

  logic       bp_hit;
  logic       cmd_acc;
  logic       idx_ok;
  logic       cmd_bad;
  logic       bp_wr;
  logic [2:0] evt_cause;
  logic       evt;

  always_comb begin
    bp_hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (bp_addr[i] == commit_pc)) bp_hit = 1'b1;
    end
  end

  always_comb begin
    cmd_acc = cmd_valid && cmd_ready;
    idx_ok  = {1'b0, cmd_idx} < NUM_BP_L;
    // STEP is meaningless while running; it is accepted but flagged.
    cmd_bad = cmd_acc && ((cmd_op > OP_CLR_BP) ||
                          (((cmd_op == OP_SET_BP) || (cmd_op == OP_CLR_BP)) && !idx_ok) ||
                          ((cmd_op == OP_STEP) && (state == ST_RUNNING)));
    bp_wr   = cmd_acc && !cmd_bad && ((cmd_op == OP_SET_BP) || (cmd_op == OP_CLR_BP));

    // Halt-event priority: illegal > ebreak > breakpoint > step completion.
    evt_cause = CAUSE_NONE;
    if (commit_valid) begin
      if (commit_ivd)                  evt_cause = CAUSE_ILLEGAL;
      else if (commit_brk)             evt_cause = CAUSE_EBREAK;
      else if (bp_hit)                 evt_cause = CAUSE_BP;
      else if (state == ST_STEPPING)   evt_cause = CAUSE_STEP;
    end
    evt = (evt_cause != CAUSE_NONE);

    state_nxt = state;
    cause_nxt = halt_cause;
    pc_nxt    = halt_pc;
    inst_nxt  = halt_inst;

    case (state)
      ST_RUNNING: begin
        if (evt) begin
          state_nxt = ST_HALTED;
          cause_nxt = evt_cause;
          pc_nxt    = commit_pc;
          inst_nxt  = commit_inst;
        end else if (cmd_acc && (cmd_op == OP_HALT)) begin
          state_nxt = ST_DRAINING;
        end
      end
      ST_DRAINING: begin
        if (evt) begin
          state_nxt = ST_HALTED;
          cause_nxt = evt_cause;
          pc_nxt    = commit_pc;
          inst_nxt  = commit_inst;
        end else begin
          // Track the last retirement so a host halt reports where it stopped.
          if (commit_valid) begin
            pc_nxt   = commit_pc;
            inst_nxt = commit_inst;
          end
          if (core_idle) begin
            state_nxt = ST_HALTED;
            cause_nxt = CAUSE_HOST;
          end
        end
      end
      ST_HALTED: begin
        if (cmd_acc && (cmd_op == OP_RUN)) begin
          state_nxt = ST_RUNNING;
          cause_nxt = CAUSE_NONE;
        end else if (cmd_acc && (cmd_op == OP_STEP)) begin
          state_nxt = ST_STEPPING;
        end
      end
      ST_STEPPING: begin
        // Any commit here is a halt event (at least STEP).
        if (evt) begin
          state_nxt = ST_HALTED;
          cause_nxt = evt_cause;
          pc_nxt    = commit_pc;
          inst_nxt  = commit_inst;
        end
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RESET;
      halt_cause <= CAUSE_RST_V;
      halt_pc    <= '0;
      halt_inst  <= '0;
      instret    <= '0;
      cmd_err    <= 1'b0;
      cmd_ready  <= 1'b1;
      core_stall <= START_HALTED;
      halted     <= START_HALTED;
      bp_en      <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
    end else begin
      state      <= state_nxt;
      halt_cause <= cause_nxt;
      halt_pc    <= pc_nxt;
      halt_inst  <= inst_nxt;
      cmd_err    <= cmd_bad;
      cmd_ready  <= (state_nxt == ST_RUNNING) || (state_nxt == ST_HALTED);
      core_stall <= (state_nxt == ST_HALTED) || (state_nxt == ST_DRAINING);
      halted     <= (state_nxt == ST_HALTED);
      if (commit_valid) instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_wr && (cmd_idx == 3'(i))) begin
          bp_en[i] <= (cmd_op == OP_SET_BP);
          if (cmd_op == OP_SET_BP) bp_addr[i] <= cmd_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// tb/tb_dbg_run_ctrl.sv - self-checking bench for dbg_run_ctrl

module tb_dbg_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reset2 = 1'b0;
  logic        cv = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst = '0;
  logic        brk = 1'b0;
  logic        ivd = 1'b0;
  logic        idle = 1'b0;
  logic        cmdv = 1'b0;
  logic [2:0]  op = '0;
  logic [2:0]  idx = '0;
  logic [31:0] addr = '0;

  logic        rdy, err, stall, hlt;
  logic [2:0]  cause;
  logic [31:0] hpc, hinst, cnt;

  logic        rdy2, err2, stall2, hlt2;
  logic [2:0]  cause2;
  logic [31:0] hpc2, hinst2;
  logic [2:0]  cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbg_run_ctrl #(.NUM_BP(4), .CNT_W(32), .START_HALTED(1'b0)) u_dut (
    .clk(clk), .reset(reset),
    .commit_valid(cv), .commit_pc(pc), .commit_inst(inst),
    .commit_brk(brk), .commit_ivd(ivd), .core_idle(idle),
    .cmd_valid(cmdv), .cmd_ready(rdy), .cmd_op(op), .cmd_idx(idx), .cmd_addr(addr),
    .cmd_err(err), .core_stall(stall), .halted(hlt), .halt_cause(cause),
    .halt_pc(hpc), .halt_inst(hinst), .instret(cnt)
  );

  dbg_run_ctrl #(.NUM_BP(1), .CNT_W(3), .START_HALTED(1'b1)) u_dut2 (
    .clk(clk), .reset(reset2),
    .commit_valid(cv), .commit_pc(pc), .commit_inst(inst),
    .commit_brk(brk), .commit_ivd(ivd), .core_idle(idle),
    .cmd_valid(cmdv), .cmd_ready(rdy2), .cmd_op(op), .cmd_idx(idx), .cmd_addr(addr),
    .cmd_err(err2), .core_stall(stall2), .halted(hlt2), .halt_cause(cause2),
    .halt_pc(hpc2), .halt_inst(hinst2), .instret(cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic [31:0] p, input logic b, input logic i,
                       input logic idl, input logic cvld, input logic [2:0] o,
                       input logic [2:0] ix, input logic [31:0] a);
    cv = c; pc = p; inst = p ^ 32'h0000_0013; brk = b; ivd = i; idle = idl;
    cmdv = cvld; op = o; idx = ix; addr = a;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        cv;
    logic [31:0] pc;
    logic        brk, ivd, idle, cmdv;
    logic [2:0]  op, idx;
    logic [31:0] addr;
    logic        e_rdy, e_stall, e_hlt;
    logic [2:0]  e_cause;
    logic [31:0] e_hpc, e_cnt;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic [31:0] p, input logic b, input logic i,
                              input logic idl, input logic cvld, input logic [2:0] o,
                              input logic [2:0] ix, input logic [31:0] a,
                              input logic r, input logic s, input logic h, input logic [2:0] ca,
                              input logic [31:0] hp, input logic [31:0] n, input logic e);
    vec_t v;
    v.cv = c; v.pc = p; v.brk = b; v.ivd = i; v.idle = idl; v.cmdv = cvld;
    v.op = o; v.idx = ix; v.addr = a;
    v.e_rdy = r; v.e_stall = s; v.e_hlt = h; v.e_cause = ca;
    v.e_hpc = hp; v.e_cnt = n; v.e_err = e;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef enum {M_RUN, M_HALT, M_DRAIN, M_STEP} mode_t;
  mode_t       m_mode;
  int          m_cause;
  logic [31:0] m_hpc, m_hinst, m_cnt;
  logic        m_err;
  logic        m_bp_on [4];
  logic [31:0] m_bp_at [4];

  task automatic model_reset();
    m_mode = M_RUN; m_cause = 0; m_hpc = 0; m_hinst = 0; m_cnt = 0; m_err = 0;
    for (int k = 0; k < 4; k++) begin
      m_bp_on[k] = 0; m_bp_at[k] = 0;
    end
  endtask

  task automatic model_step();
    bit ready, acc, bad, hit;
    int ev;
    ready = (m_mode == M_RUN) || (m_mode == M_HALT);
    acc   = cmdv && ready;
    bad   = acc && ((op > 4) || ((op == 3 || op == 4) && idx >= 4) || (op == 2 && m_mode == M_RUN));
    hit   = 0;
    for (int k = 0; k < 4; k++) if (m_bp_on[k] && m_bp_at[k] == pc) hit = 1;
    ev = 0;
    if (cv) begin
      if (ivd) ev = 6;
      else if (brk) ev = 5;
      else if (hit) ev = 4;
      else if (m_mode == M_STEP) ev = 3;
    end
    if (cv) m_cnt = m_cnt + 1;
    if (m_mode != M_HALT && ev != 0) begin
      m_mode = M_HALT; m_cause = ev; m_hpc = pc; m_hinst = inst;
    end else begin
      case (m_mode)
        M_RUN:   if (acc && op == 1) m_mode = M_DRAIN;
        M_DRAIN: begin
          if (cv) begin m_hpc = pc; m_hinst = inst; end
          if (idle) begin m_mode = M_HALT; m_cause = 2; end
        end
        M_HALT: begin
          if (acc && op == 0) begin m_mode = M_RUN; m_cause = 0; end
          else if (acc && op == 2) m_mode = M_STEP;
        end
        default: ;
      endcase
    end
    if (acc && !bad && op == 3) begin m_bp_on[idx] = 1; m_bp_at[idx] = addr; end
    if (acc && !bad && op == 4) m_bp_on[idx] = 0;
    m_err = bad;
  endtask

  vec_t tbl [31];

  initial begin
    for (int i = 0; i < 5; i++)
      tbl[i] = mk(1, 32'h8000_1000 + 32'(4 * i), 0, 0, 1, 0, 0, 0, 0,
                  1, 0, 0, 0, 0, 32'(i + 1), 0);
    tbl[5]  = mk(0, 0,            0,0,1, 1,3,1,32'h8000_0010, 1,0,0,0,0,            5,0);
    tbl[6]  = mk(1, 32'h8000_0008,0,0,1, 0,0,0,0,             1,0,0,0,0,            6,0);
    tbl[7]  = mk(1, 32'h8000_000C,0,0,1, 0,0,0,0,             1,0,0,0,0,            7,0);
    tbl[8]  = mk(1, 32'h8000_0010,0,0,1, 0,0,0,0,             1,1,1,4,32'h8000_0010,8,0);
    tbl[9]  = mk(0, 0,            0,0,0, 1,2,0,0,             0,0,0,4,32'h8000_0010,8,0);
    tbl[10] = mk(1, 32'h8000_0014,0,0,0, 0,0,0,0,             1,1,1,3,32'h8000_0014,9,0);
    tbl[11] = mk(0, 0,            0,0,0, 1,0,0,0,             1,0,0,0,32'h8000_0014,9,0);
    tbl[12] = mk(0, 0,            0,0,0, 1,1,0,0,             0,1,0,0,32'h8000_0014,9,0);
    tbl[13] = mk(0, 0,            0,0,0, 0,0,0,0,             0,1,0,0,32'h8000_0014,9,0);
    tbl[14] = mk(0, 0,            0,0,0, 0,0,0,0,             0,1,0,0,32'h8000_0014,9,0);
    tbl[15] = mk(0, 0,            0,0,1, 0,0,0,0,             1,1,1,2,32'h8000_0014,9,0);
    tbl[16] = mk(0, 0,            0,0,0, 1,0,0,0,             1,0,0,0,32'h8000_0014,9,0);
    tbl[17] = mk(0, 0,            0,0,0, 1,3,2,32'h8000_0020, 1,0,0,0,32'h8000_0014,9,0);
    tbl[18] = mk(1, 32'h8000_0020,1,1,0, 1,1,0,0,             1,1,1,6,32'h8000_0020,10,0);
    tbl[19] = mk(0, 0,            0,0,0, 1,0,0,0,             1,0,0,0,32'h8000_0020,10,0);
    tbl[20] = mk(0, 0,            0,0,0, 1,3,7,32'h8000_0030, 1,0,0,0,32'h8000_0020,10,1);
    tbl[21] = mk(1, 32'h8000_0030,0,0,0, 0,0,0,0,             1,0,0,0,32'h8000_0020,11,0);
    tbl[22] = mk(0, 0,            0,0,0, 1,2,0,0,             1,0,0,0,32'h8000_0020,11,1);
    tbl[23] = mk(0, 0,            0,0,0, 1,5,0,0,             1,0,0,0,32'h8000_0020,11,1);
    tbl[24] = mk(1, 32'h8000_0020,0,0,0, 0,0,0,0,             1,1,1,4,32'h8000_0020,12,0);
    tbl[25] = mk(0, 0,            0,0,0, 1,4,2,0,             1,1,1,4,32'h8000_0020,12,0);
    tbl[26] = mk(0, 0,            0,0,0, 1,0,0,0,             1,0,0,0,32'h8000_0020,12,0);
    tbl[27] = mk(1, 32'h8000_0020,0,0,0, 0,0,0,0,             1,0,0,0,32'h8000_0020,13,0);
    tbl[28] = mk(0, 32'h8000_0010,1,1,0, 0,0,0,0,             1,0,0,0,32'h8000_0020,13,0);
    tbl[29] = mk(1, 32'h8000_0044,1,0,0, 0,0,0,0,             1,1,1,5,32'h8000_0044,14,0);
    tbl[30] = mk(1, 32'h8000_0048,0,0,0, 0,0,0,0,             1,1,1,5,32'h8000_0044,15,0);

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_ready", rdy, 1); chk("rst_stall", stall, 0); chk("rst_halted", hlt, 0);
    chk("rst_cause", cause, 0); chk("rst_hpc", hpc, 0); chk("rst_instret", cnt, 0);
    chk("rst_err", err, 0);

    // table
    for (int i = 0; i < 31; i++) begin
      drive(tbl[i].cv, tbl[i].pc, tbl[i].brk, tbl[i].ivd, tbl[i].idle, tbl[i].cmdv,
            tbl[i].op, tbl[i].idx, tbl[i].addr);
      tick();
      chk($sformatf("v%0d_ready", i),   rdy,   tbl[i].e_rdy);
      chk($sformatf("v%0d_stall", i),   stall, tbl[i].e_stall);
      chk($sformatf("v%0d_halted", i),  hlt,   tbl[i].e_hlt);
      chk($sformatf("v%0d_cause", i),   cause, tbl[i].e_cause);
      chk($sformatf("v%0d_hpc", i),     hpc,   tbl[i].e_hpc);
      chk($sformatf("v%0d_instret", i), cnt,   tbl[i].e_cnt);
      chk($sformatf("v%0d_err", i),     err,   tbl[i].e_err);
    end

    // drain with a plain commit, then idle: HOST cause keeps the drained PC
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0); tick();
    chk("drain_stall", stall, 1); chk("drain_ready", rdy, 0); chk("drain_halted", hlt, 0);
    drive(1, 32'h8000_0050, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("drain_commit_hpc", hpc, 32'h8000_0050); chk("drain_commit_halted", hlt, 0);
    chk("drain_commit_cnt", cnt, 16);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0); tick();
    chk("drain_idle_halted", hlt, 1); chk("drain_idle_cause", cause, 2);
    chk("drain_idle_hpc", hpc, 32'h8000_0050);
    chk("drain_idle_hinst", hinst, 32'h8000_0050 ^ 32'h13);

    // reset mid-drain aborts immediately, breakpoints cleared
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_abort_stall", stall, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_ready", rdy, 1); chk("abort_stall", stall, 0); chk("abort_halted", hlt, 0);
    chk("abort_cause", cause, 0); chk("abort_cnt", cnt, 0); chk("abort_hpc", hpc, 0);
    reset = 1'b1;
    drive(1, 32'h8000_0010, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("bp_cleared_halted", hlt, 0); chk("bp_cleared_cnt", cnt, 1);

    // second instance: START_HALTED, NUM_BP=1, 3-bit counter wrap
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset2 = 1'b1;
    #1;
    chk("sh_halted", hlt2, 1); chk("sh_cause", cause2, 1); chk("sh_stall", stall2, 1);
    chk("sh_ready", rdy2, 1); chk("sh_cnt", cnt2, 0);
    drive(1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0);
    repeat (7) tick();
    chk("sh_cnt7", cnt2, 7); chk("sh_commit_halted", hlt2, 1); chk("sh_commit_hpc", hpc2, 0);
    tick();
    chk("sh_wrap", cnt2, 0); chk("sh_wrap_cause", cause2, 1);
    drive(0, 0, 0, 0, 0, 1, 3, 1, 32'h8000_0200); tick();
    chk("sh_bad_idx_err", err2, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("sh_err_pulse", err2, 0);

    // randomized run against the reference model
    reset = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      cv   = 1'($urandom % 2);
      pc   = 32'h8000_0000 + 32'(4 * ($urandom % 8));
      inst = $urandom;
      brk  = ($urandom % 16) == 0;
      ivd  = ($urandom % 20) == 0;
      idle = ($urandom % 3) == 0;
      cmdv = ($urandom % 3) == 0;
      op   = (($urandom % 10) < 8) ? 3'($urandom % 5) : 3'($urandom % 8);
      idx  = 3'($urandom % 6);
      addr = 32'h8000_0000 + 32'(4 * ($urandom % 8));
      model_step();
      tick();
      chk("rnd_ready",   rdy,   (m_mode == M_RUN || m_mode == M_HALT));
      chk("rnd_stall",   stall, (m_mode == M_HALT || m_mode == M_DRAIN));
      chk("rnd_halted",  hlt,   (m_mode == M_HALT));
      chk("rnd_cause",   cause, 64'(m_cause));
      chk("rnd_hpc",     hpc,   m_hpc);
      chk("rnd_hinst",   hinst, m_hinst);
      chk("rnd_instret", cnt,   m_cnt);
      chk("rnd_err",     err,   m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
